// File: rtl/lcd_pkg.sv
// Shared opcodes, FSM state type and byte helpers for the LCD fill path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
    localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
    localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ARG,
        PIX,
        FINISH
    } lcd_state_t;

    // Window setup runs CASET -> RASET -> RAMWR; RAMWR is terminal.
    function automatic logic [7:0] lcd_next_cmd(input logic [7:0] cmd);
        return (cmd == LCD_CMD_CASET) ? LCD_CMD_RASET : LCD_CMD_RAMWR;
    endfunction

    // Argument bytes go out as start hi, start lo, end hi, end lo.
    function automatic logic [7:0] lcd_arg_byte(input logic [15:0] lo,
                                                input logic [15:0] hi,
                                                input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = lo[15:8];
            2'd1:    b = lo[7:0];
            2'd2:    b = hi[15:8];
            default: b = hi[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_fill_sequencer_if.sv
// Sequencer <-> serializer link: FWFT byte/pixel slots plus panel DC/CS.
// Latency: wires only.
// Backpressure: the serializer acknowledges each offered word with d8_read/d16_read.
// Ports: d8_empty/d8_data/d8_read     byte slot (opcodes and arguments)
//        d16_empty/d16_data/d16_read  pixel slot
//        lcd_busy                     serializer still shifting
//        lcd_dc, lcd_cs_n             panel data/command select and chip select
interface lcd_fill_sequencer_if;

    logic        d8_empty;
    logic [7:0]  d8_data;
    logic        d8_read;
    logic        d16_empty;
    logic [15:0] d16_data;
    logic        d16_read;
    logic        lcd_busy;
    logic        lcd_dc;
    logic        lcd_cs_n;

    modport master (
        output d8_empty, d8_data, d16_empty, d16_data, lcd_dc, lcd_cs_n,
        input  d8_read, d16_read, lcd_busy
    );

    modport slave (
        input  d8_empty, d8_data, d16_empty, d16_data, lcd_dc, lcd_cs_n,
        output d8_read, d16_read, lcd_busy
    );

endinterface

// File: rtl/lcd_word_slot.sv
// One-entry offer register shared by the 8-bit and 16-bit FWFT ports.
// Latency: fills on the edge after load, clears on the edge after a matching read.
// Backpressure: load is ignored while any word is offered; reads with no offer are ignored.
// Ports: clk, rst          clock and synchronous active-high reset
//        load, sel16, load_data  fill request, width select, word to offer
//        rd8, rd16         consumer acknowledges
//        d8_*/d16_*        offered words and their empty flags; full = either offered
module lcd_word_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        sel16,
    input  logic [15:0] load_data,
    input  logic        rd8,
    input  logic        rd16,
    output logic        d8_empty,
    output logic [7:0]  d8_data,
    output logic        d16_empty,
    output logic [15:0] d16_data,
    output logic        full
);

    assign full = !d8_empty || !d16_empty;

    // Data registers only move on load, so they stay stable for the whole offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            d8_empty  <= 1'b1;
            d16_empty <= 1'b1;
            d8_data   <= 8'h00;
            d16_data  <= 16'h0000;
        end else begin
            if (!d8_empty && rd8) begin
                d8_empty <= 1'b1;
            end
            if (!d16_empty && rd16) begin
                d16_empty <= 1'b1;
            end
            if (load && !full) begin
                if (sel16) begin
                    d16_empty <= 1'b0;
                    d16_data  <= load_data;
                end else begin
                    d8_empty <= 1'b0;
                    d8_data  <= load_data[7:0];
                end
            end
        end
    end

endmodule

// File: rtl/lcd_fill_sequencer.sv
// Turns a rectangle-fill request into CASET/RASET/RAMWR + pixel stream for the SPI serializer.
// Latency: busy/cs_n assert one cycle after start; done pulses one cycle after the final drain.
// Backpressure: one word in flight; each waits for its read, DC changes wait for slot empty and lcd_busy low.
// Ports: clk, rst                 clock and synchronous active-high reset
//        start, x0..y1, color     fill request (window inclusive), sampled when accepted
//        busy, done, err          status; err accompanies done for an inverted window
//        lcd (master)             FWFT slots, lcd_busy, lcd_dc, lcd_cs_n
module lcd_fill_sequencer
    import lcd_pkg::*;
#(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] y1,
    input  logic [15:0]        color,
    output logic               busy,
    output logic               done,
    output logic               err,
    lcd_fill_sequencer_if.master lcd
);

    localparam logic [COORD_W:0] CNT_ONE = (COORD_W+1)'(1);

    lcd_state_t state, state_nxt;

    logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
    logic [15:0]        color_q;
    logic [7:0]         op_q;
    logic [1:0]         arg_idx;
    logic               issued;
    // One bit wider than the coordinates so a full 0..2^COORD_W-1 span never wraps.
    logic [COORD_W:0]   col_q, row_q;
    logic               dc_q, cs_n_q;

    logic        slot_full, slot_load, slot_sel16;
    logic [15:0] slot_din;
    logic        win_ok, drained, dc_ok, taken, last_pix;
    logic        accept, reject, fin, dc_set, dc_clr, word_done;
    logic [15:0] win_lo, win_hi;

    assign lcd.lcd_dc   = dc_q;
    assign lcd.lcd_cs_n = cs_n_q;

    assign win_ok   = (x1 >= x0) && (y1 >= y0);
    assign drained  = !slot_full && !lcd.lcd_busy;
    // A data word may follow another data word without waiting for the shifter;
    // only a DC flip needs the full drain.
    assign dc_ok    = !slot_full && (dc_q || !lcd.lcd_busy);
    // issued is set on the load edge, so the slot is full by the time issued is
    // seen; an empty slot afterwards means the serializer took the word.
    assign taken    = issued && !slot_full;
    assign last_pix = (col_q == {1'b0, x1_q}) && (row_q == {1'b0, y1_q});
    assign win_lo   = (op_q == LCD_CMD_CASET) ? 16'(x0_q) : 16'(y0_q);
    assign win_hi   = (op_q == LCD_CMD_CASET) ? 16'(x1_q) : 16'(y1_q);

    lcd_word_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .sel16     (slot_sel16),
        .load_data (slot_din),
        .rd8       (lcd.d8_read),
        .rd16      (lcd.d16_read),
        .d8_empty  (lcd.d8_empty),
        .d8_data   (lcd.d8_data),
        .d16_empty (lcd.d16_empty),
        .d16_data  (lcd.d16_data),
        .full      (slot_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && win_ok) state_nxt = CMD;
            // The opcode must be fully shifted before DC flips to data.
            CMD:     if (issued && drained)
                         state_nxt = (op_q == LCD_CMD_RAMWR) ? PIX : ARG;
            ARG:     if (taken && (arg_idx == 2'd3)) state_nxt = CMD;
            PIX:     if (taken && last_pix) state_nxt = FINISH;
            FINISH:  if (drained) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept     = 1'b0;
        reject     = 1'b0;
        fin        = 1'b0;
        slot_load  = 1'b0;
        slot_sel16 = 1'b0;
        slot_din   = 16'h0000;
        dc_set     = 1'b0;
        dc_clr     = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                accept = start && win_ok;
                reject = start && !win_ok;
            end
            CMD: begin
                if (!issued && drained) begin
                    slot_load = 1'b1;
                    slot_din  = {8'h00, op_q};
                    dc_clr    = 1'b1;
                end
                word_done = issued && drained;
            end
            ARG: begin
                if (!issued && dc_ok) begin
                    slot_load = 1'b1;
                    slot_din  = {8'h00, lcd_arg_byte(win_lo, win_hi, arg_idx)};
                    dc_set    = 1'b1;
                end
                word_done = taken;
            end
            PIX: begin
                if (!issued && dc_ok) begin
                    slot_load  = 1'b1;
                    slot_sel16 = 1'b1;
                    slot_din   = color_q;
                    dc_set     = 1'b1;
                end
                word_done = taken;
            end
            FINISH: begin
                fin = drained;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            dc_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            issued  <= 1'b0;
            arg_idx <= 2'd0;
            op_q    <= LCD_CMD_CASET;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= 16'h0000;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            done <= fin || reject;
            err  <= reject;

            if (accept) begin
                x0_q    <= x0;
                x1_q    <= x1;
                y0_q    <= y0;
                y1_q    <= y1;
                color_q <= color;
                col_q   <= {1'b0, x0};
                row_q   <= {1'b0, y0};
                op_q    <= LCD_CMD_CASET;
                arg_idx <= 2'd0;
                busy    <= 1'b1;
                cs_n_q  <= 1'b0;
            end

            if (slot_load) begin
                issued <= 1'b1;
            end else if (word_done) begin
                issued <= 1'b0;
            end

            if (dc_clr) begin
                dc_q <= 1'b0;
            end else if (dc_set) begin
                dc_q <= 1'b1;
            end

            if ((state == ARG) && taken) begin
                arg_idx <= arg_idx + 2'd1;
                if (arg_idx == 2'd3) begin
                    op_q <= lcd_next_cmd(op_q);
                end
            end

            // Raster walk: column x0..x1 within each row y0..y1.
            if ((state == PIX) && taken) begin
                if (col_q == {1'b0, x1_q}) begin
                    col_q <= {1'b0, x0_q};
                    row_q <= row_q + CNT_ONE;
                end else begin
                    col_q <= col_q + CNT_ONE;
                end
            end

            // Leave the panel deselected in command mode, matching reset.
            if (fin) begin
                busy   <= 1'b0;
                cs_n_q <= 1'b1;
                dc_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
// Randomized bench for lcd_fill_sequencer with a behavioural serializer and word-list model.
// Latency: n/a.
// Backpressure: serializer model stays busy for a random 1..4 cycles after each word.
module tb_lcd_fill_sequencer;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] x0, x1, y0, y1;
    logic [15:0]   color;
    logic          busy, done, err;

    lcd_fill_sequencer_if lcd ();

    lcd_fill_sequencer #(.COORD_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x0    (x0),
        .x1    (x1),
        .y0    (y0),
        .y1    (y1),
        .color (color),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .lcd   (lcd)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Word record: [18]=pixel, [17]=dc, [16]=cs_n, [15:0]=data
    logic [18:0] log_q[$];
    logic [18:0] exp_q[$];
    int          done_cnt = 0;
    logic        last_err = 1'b0;
    int          ser_cnt  = 0;

    // Serializer model and bus monitor, evaluated on every falling edge.
    initial begin
        logic       prev_dc, prev_busy, prev_full, prev_d8v, prev_d16v;
        logic [7:0] prev_d8;
        logic [15:0] prev_d16;
        prev_dc = 1'b0; prev_busy = 1'b0; prev_full = 1'b0;
        prev_d8v = 1'b0; prev_d16v = 1'b0; prev_d8 = 8'h00; prev_d16 = 16'h0000;
        lcd.d8_read  = 1'b0;
        lcd.d16_read = 1'b0;
        lcd.lcd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (lcd.lcd_dc !== prev_dc) begin
                    check("dc_edge_while_busy", prev_busy, 0);
                    check("dc_edge_while_full", prev_full, 0);
                end
                if (prev_d8v && !lcd.d8_empty)   check("d8_hold", lcd.d8_data, prev_d8);
                if (prev_d16v && !lcd.d16_empty) check("d16_hold", lcd.d16_data, prev_d16);
                if (done) begin
                    done_cnt++;
                    last_err = err;
                    if (!err) begin
                        check("done_before_drain_busy", lcd.lcd_busy, 0);
                        check("done_before_drain_slot", {lcd.d8_empty, lcd.d16_empty}, 2'b11);
                    end
                end
            end
            lcd.d8_read  = 1'b0;
            lcd.d16_read = 1'b0;
            if (lcd.lcd_busy) begin
                ser_cnt--;
                if (ser_cnt == 0) lcd.lcd_busy = 1'b0;
            end else if (lcd.d8_empty === 1'b0) begin
                log_q.push_back({1'b0, lcd.lcd_dc, lcd.lcd_cs_n, 8'h00, lcd.d8_data});
                lcd.d8_read  = 1'b1;
                lcd.lcd_busy = 1'b1;
                ser_cnt      = $urandom_range(1, 4);
            end else if (lcd.d16_empty === 1'b0) begin
                log_q.push_back({1'b1, lcd.lcd_dc, lcd.lcd_cs_n, lcd.d16_data});
                lcd.d16_read = 1'b1;
                lcd.lcd_busy = 1'b1;
                ser_cnt      = $urandom_range(1, 4);
            end
            prev_dc   = lcd.lcd_dc;
            prev_busy = lcd.lcd_busy;
            prev_full = !lcd.d8_empty || !lcd.d16_empty;
            prev_d8v  = !lcd.d8_empty;
            prev_d16v = !lcd.d16_empty;
            prev_d8   = lcd.d8_data;
            prev_d16  = lcd.d16_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected panel transaction list for one fill, straight from the command format.
    function automatic void build_exp(input int ax0, input int ax1, input int ay0,
                                      input int ay1, input logic [15:0] c);
        int xv[4];
        int yv[4];
        xv = '{ax0 >> 8, ax0 & 255, ax1 >> 8, ax1 & 255};
        yv = '{ay0 >> 8, ay0 & 255, ay1 >> 8, ay1 & 255};
        exp_q.delete();
        exp_q.push_back({3'b000, 16'h002A});
        for (int j = 0; j < 4; j++) exp_q.push_back({3'b010, 8'h00, xv[j][7:0]});
        exp_q.push_back({3'b000, 16'h002B});
        for (int j = 0; j < 4; j++) exp_q.push_back({3'b010, 8'h00, yv[j][7:0]});
        exp_q.push_back({3'b000, 16'h002C});
        for (int j = 0; j < (ax1 - ax0 + 1) * (ay1 - ay0 + 1); j++)
            exp_q.push_back({3'b110, c});
    endfunction

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_busy"},      busy, 0);
        check({pfx, "_done"},      done, 0);
        check({pfx, "_err"},       err, 0);
        check({pfx, "_d8_empty"},  lcd.d8_empty, 1);
        check({pfx, "_d16_empty"}, lcd.d16_empty, 1);
        check({pfx, "_d8_data"},   lcd.d8_data, 0);
        check({pfx, "_d16_data"},  lcd.d16_data, 0);
        check({pfx, "_lcd_dc"},    lcd.lcd_dc, 0);
        check({pfx, "_lcd_cs_n"},  lcd.lcd_cs_n, 1);
    endtask

    task automatic wait_quiet();
        int cyc;
        cyc = 0;
        while ((lcd.lcd_busy || busy) && cyc < 1000) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                            input logic [15:0] c, input bit repulse);
        int cyc, npix, nchk;
        bit pulsed;
        wait_quiet();
        build_exp(ax0, ax1, ay0, ay1, c);
        log_q.delete();
        done_cnt = 0;
        x0 = ax0[CW-1:0]; x1 = ax1[CW-1:0]; y0 = ay0[CW-1:0]; y1 = ay1[CW-1:0];
        color = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_rise", busy, 1);
        check("cs_low", lcd.lcd_cs_n, 0);
        cyc = 0;
        pulsed = 1'b0;
        while (done_cnt == 0 && cyc < 20000) begin
            if (repulse && !pulsed && !lcd.d16_empty) begin
                x0 = '0; x1 = '0; y0 = '0; y1 = '0;
                start = 1'b1;
                tick();
                start = 1'b0;
                pulsed = 1'b1;
            end else begin
                tick();
            end
            cyc++;
        end
        check("done_seen", (done_cnt != 0), 1);
        if (repulse) check("repulse_applied", pulsed, 1);
        check("done_err", last_err, 0);
        check("busy_fall", busy, 0);
        check("cs_high", lcd.lcd_cs_n, 1);
        repeat (6) tick();
        check("done_once", done_cnt, 1);
        npix = 0;
        foreach (log_q[i]) if (log_q[i][18]) npix++;
        check("pixel_count", npix, (ax1 - ax0 + 1) * (ay1 - ay0 + 1));
        check("word_count", log_q.size(), exp_q.size());
        nchk = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++)
            check($sformatf("word%0d", i), log_q[i], exp_q[i]);
    endtask

    task automatic run_invalid(input int ax0, input int ax1, input int ay0, input int ay1);
        wait_quiet();
        log_q.delete();
        done_cnt = 0;
        x0 = ax0[CW-1:0]; x1 = ax1[CW-1:0]; y0 = ay0[CW-1:0]; y1 = ay1[CW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check("inv_done", done, 1);
        check("inv_err", err, 1);
        check("inv_busy", busy, 0);
        check("inv_cs", lcd.lcd_cs_n, 1);
        repeat (8) begin
            tick();
            check("inv_cs_hold", lcd.lcd_cs_n, 1);
            check("inv_no_offer", {lcd.d8_empty, lcd.d16_empty}, 2'b11);
        end
        check("inv_done_once", done_cnt, 1);
        check("inv_words", log_q.size(), 0);
    endtask

    task automatic run_reset_mid();
        int cyc;
        wait_quiet();
        log_q.delete();
        x0 = 8'd2; x1 = 8'd5; y0 = 8'd1; y1 = 8'd4;
        color = 16'hBEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (log_q.size() < 3 && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("mid_arg_reached", (log_q.size() >= 3), 1);
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        tick();
        run_fill(7, 7, 9, 9, 16'h1234, 1'b0);
    endtask

    initial begin
        int a, b, w, h;
        rst = 1'b1;
        start = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        color = 16'h0000;
        repeat (3) tick();
        check_reset_vals("por");
        rst = 1'b0;
        tick();

        run_fill(0, 1, 0, 0, 16'hF800, 1'b0);
        run_fill(3, 12, 20, 29, 16'h07E0, 1'b0);
        run_invalid(5, 4, 0, 0);
        run_invalid(0, 0, 9, 3);
        run_fill(16, 23, 40, 47, 16'h001F, 1'b1);
        run_reset_mid();
        run_fill(0, 255, 0, 0, 16'hA5A5, 1'b0);
        run_fill(255, 255, 255, 255, 16'h5A5A, 1'b0);

        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, 250);
            b = $urandom_range(0, 250);
            w = $urandom_range(0, 5);
            h = $urandom_range(0, 3);
            run_fill(a, a + w, b, b + h, 16'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lcd_fill_sequencer.md
Name: lcd_fill_sequencer

Overview:
- Upstream command/pixel source for lcd_spi_serializer.
- Turns one rectangle-fill request into a panel command sequence: CASET (0x2A) with 4 argument bytes, RASET (0x2B) with 4 argument bytes, RAMWR (0x2C), then a stream of 16-bit pixels.
- Presents first-word-fall-through slot interfaces on the serializer's d8/d16 ports.
- Drives lcd_dc and lcd_cs_n, changing lcd_dc only when the serializer has fully drained.

Parameters:
- COORD_W, 8, coordinate width; zero-extended to 16 bits in CASET/RASET arguments.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request pulse; ignored while busy
- x0, x1, y0, y1  in  COORD_W each  inclusive window; sampled on an accepted start
- color  in  16  fill colour; sampled on an accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse for a rejected window (x1<x0 or y1<y0); accompanies done
- d8_empty  out  1  low while an 8-bit word is offered
- d8_data  out  8  offered byte
- d8_read  in  1  serializer acknowledge; offered byte already taken
- d16_empty  out  1  low while a pixel is offered
- d16_data  out  16  offered pixel
- d16_read  in  1  serializer acknowledge; offered pixel already taken
- lcd_busy  in  1  serializer shifting
- lcd_dc  out  1  0 = command, 1 = data
- lcd_cs_n  out  1  panel chip select, active low

Behaviour:
- Reset values: busy=0, done=0, err=0, d8_empty=1, d16_empty=1, d8_data=0, d16_data=0, lcd_dc=0, lcd_cs_n=1. Reset mid-operation abandons the sequence immediately; any word already taken by the serializer finishes independently.
- Slot rule: at most one word offered across both interfaces at any time.
  - The slot fills on the edge after the state requests it.
  - The slot clears on the edge after the cycle in which d*_read=1.
  - A read with no offer is ignored.
  - d8_data/d16_data are held stable while the corresponding empty=0.
- Drain rule: before any lcd_dc change (and before done), wait until the slot is empty and lcd_busy=0 in the same cycle. This is safe because d*_read and lcd_busy rise together.
- States:
  - IDLE: on start with a valid window, latch inputs, busy=1, lcd_cs_n=0 next cycle, go to CMD with op=CASET. On start with an invalid window, pulse done and err the next cycle and stay IDLE; lcd_cs_n is untouched.
  - CMD: drain, set lcd_dc=0, offer the opcode on d8, wait for d8_read, then drain.
    - CASET/RASET go to ARG.
    - RAMWR goes to PIX.
  - ARG: set lcd_dc=1 and offer 4 bytes in order: start hi, start lo, end hi, end lo.
    - CASET uses x0/x1; RASET uses y0/y1.
    - Each byte waits for its own d8_read.
    - Then CMD with the next op.
  - PIX: lcd_dc=1 and lcd_cs_n stays 0. Offer colour on d16 (width)*(height) times.
    - Counted with a column counter (x0..x1) and a row counter (y0..y1); no multiplier.
    - The last pixel is at column x1, row y1.
  - FINISH: drain, then lcd_cs_n=1, busy=0, done=1 for one cycle, go to IDLE.
- Boundaries:
  - A 1x1 window sends exactly one pixel.
  - A full window (0..2^COORD_W-1) must not let counters wrap early; counters are COORD_W+1 bits wide.
  - start during busy is dropped with no side effect.
  - d8_read and d16_read are never both legal in one cycle.

Decomposition:
- Shared package lcd_pkg holds:
  - LCD_CMD_CASET=8'h2A, LCD_CMD_RASET=8'h2B, LCD_CMD_RAMWR=8'h2C
  - the state enum (IDLE, CMD, ARG, PIX, FINISH)
- Sub-module lcd_word_slot: one-entry offer/acknowledge register with load, 8/16 select, empty flags and data outputs. It holds the slot rule so the sequencer FSM carries only the sequencing logic.

Test Plan:
- Window x 0..1, y 0..0, colour 16'hF800, serializer model attached:
  - Expected byte stream 2A, 00 00 00 01, 2B, 00 00 00 00, 2C, then pixels F800 F800.
  - lcd_dc=0 exactly during both opcode transfers and the RAMWR transfer.
  - done after the last sclk.
- Drain timing: no lcd_dc edge while lcd_busy=1 or while the slot is full. Checked by assertion across a 10x10 fill (100 pixels).
- Invalid window x0=5, x1=4:
  - done=1 and err=1 one cycle after start.
  - lcd_cs_n stays 1; no d8/d16 offers.
- start re-pulsed during PIX of an 8x8 fill: ignored; exactly 64 pixels; one done.
- Reset asserted mid-ARG:
  - Next cycle all outputs at reset values.
  - A following 1x1 request completes normally.
- Full window 0..255 x 0..0 with COORD_W=8: exactly 256 pixels, with no premature counter wrap.
